cpu_wb_port_arbiter: RTL

Shares the single register-file write port between the ALU/memory writeback path and the multiplier writeback path.
- ALU writes always win.
- Multiplier results are held in a small in-order buffer and drained into idle write slots.
- A forwarding query port exposes buffered, not-yet-written results to the FWUnit.
- A starvation guard stalls the ALU path when buffered results have waited too long.

---
 rtl/cpu_wb_port_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cpu_wb_port_arbiter.sv
// Register-file write-port arbiter: ALU writes win, multiplier results wait in an
// in-order buffer with WAW kill, forwarding and a starvation guard. Option: WB_MUL_BYPASS_EN.
module cpu_wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 4,
    parameter int MAX_DEFER  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  mul_valid,
    input  logic [REG_ADDR_W-1:0] mul_rd,
    input  logic [DATA_W-1:0]     mul_data,
    output logic                  mul_ready,
    output logic                  alu_stall,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    input  logic [REG_ADDR_W-1:0] q_rd,
    output logic                  q_hit,
    output logic [DATA_W-1:0]     q_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DEF_W = $clog2(MAX_DEFER + 1);

    logic [REG_ADDR_W-1:0] buf_rd_q   [DEPTH];
    logic [DATA_W-1:0]     buf_data_q [DEPTH];

    logic [DEPTH-1:0] live_q, live_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEF_W-1:0] defer_q, defer_d;
    logic             alu_stall_q, alu_stall_d;

    logic alu_win, empty, push_ok, head_live, bypass, drain, pop, push;

    always_comb begin
        alu_win   = alu_valid && (alu_rd != '0);
        empty     = (count_q == '0);
        mul_ready = !reset && (count_q < CNT_W'(DEPTH));
        push_ok   = mul_valid && mul_ready && (mul_rd != '0);
        head_live = !empty && live_q[head_q];
`ifdef WB_MUL_BYPASS_EN
        bypass    = empty && !alu_valid && push_ok;
`else
        bypass    = 1'b0;
`endif
        drain     = head_live && !alu_win;
        // Dead heads leave the queue regardless of who owns the port.
        pop       = !empty && (!live_q[head_q] || !alu_win);
        push      = push_ok && !bypass;
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (!reset) begin
            if (alu_win) begin
                rf_we    = 1'b1;
                rf_waddr = alu_rd;
                rf_wdata = alu_data;
            end else if (head_live) begin
                rf_we    = 1'b1;
                rf_waddr = buf_rd_q[head_q];
                rf_wdata = buf_data_q[head_q];
            end else if (bypass) begin
                rf_we    = 1'b1;
                rf_waddr = mul_rd;
                rf_wdata = mul_data;
            end
        end
    end

    always_comb begin
        live_d = live_q;
        if (pop) begin
            live_d[head_q] = 1'b0;
        end
        // Buffered results are program-older than a concurrent ALU write to the same rd.
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_win && (buf_rd_q[i] == alu_rd)) begin
                live_d[i] = 1'b0;
            end
        end
        if (push) begin
            live_d[tail_q] = !(alu_win && (alu_rd == mul_rd));
        end
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        defer_d = defer_q;
        if (empty || drain) begin
            defer_d = '0;
        end else if (head_live && alu_win && (defer_q != DEF_W'(MAX_DEFER))) begin
            defer_d = defer_q + 1'b1;
        end
        alu_stall_d = (defer_d == DEF_W'(MAX_DEFER));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            live_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            defer_q     <= '0;
            alu_stall_q <= 1'b0;
        end else begin
            live_q      <= live_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            defer_q     <= defer_d;
            alu_stall_q <= alu_stall_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            buf_rd_q[tail_q]   <= mul_rd;
            buf_data_q[tail_q] <= mul_data;
        end
    end

    assign alu_stall = alu_stall_q;

    // Match vector in age order, oldest first, so the last hit is the youngest.
    logic [PTR_W-1:0] age_idx [DEPTH];
    logic [DEPTH-1:0] q_match;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
            assign age_idx[gi] = head_q + PTR_W'(gi);
            assign q_match[gi] = (CNT_W'(gi) < count_q) && live_q[age_idx[gi]]
                                 && (buf_rd_q[age_idx[gi]] == q_rd);
        end
    endgenerate

    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        if (q_rd != '0) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q_match[i]) begin
                    q_hit  = 1'b1;
                    q_data = buf_data_q[age_idx[i]];
                end
            end
        end
    end

endmodule
